// File: rtl/left_signal_head_monitor_pkg.sv
// Shared types for the left-turn signal head monitor.
//   light_t     : 2-bit light_color code, shared with the light controller
//   fault_t     : latched fault cause reported on fault_code
//   mon_state_t : monitor FSM state
//   is_legal    : which code-to-code transitions the controller may make
package left_signal_pkg;

  typedef enum logic [1:0] {
    L_GREEN           = 2'b00,
    L_YELLOW          = 2'b01,
    L_RED             = 2'b10,
    L_FLASHING_YELLOW = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    F_NONE         = 2'b00,
    F_ILLEGAL      = 2'b01,
    F_SHORT_YELLOW = 2'b10,
    F_STUCK        = 2'b11
  } fault_t;

  typedef enum logic [0:0] {
    MON_MONITOR = 1'b0,
    MON_FAULT   = 1'b1
  } mon_state_t;

  // Only meaningful when from != to.
  function automatic logic is_legal(light_t from, light_t to);
    logic ok;
    ok = 1'b0;
    unique case (from)
      L_GREEN:           ok = (to == L_YELLOW);
      L_YELLOW:          ok = (to == L_RED);
      L_RED:             ok = (to == L_GREEN) || (to == L_FLASHING_YELLOW);
      L_FLASHING_YELLOW: ok = (to == L_YELLOW);
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/left_signal_head_monitor_if.sv
// Bus between the left-turn light controller (master) and the signal head monitor (slave).
//   light_color  controller -> monitor  2-bit light code
//   hold         controller -> monitor  controller paused, freezes the dwell watchdog
//   clear_fault  controller -> monitor  fault clear request (level)
//   lamp_*       monitor -> lamps       lamp enables
//   fault        monitor -> controller  fault latched
//   fault_code   monitor -> controller  latched fault cause
interface left_signal_head_monitor_if;
  import left_signal_pkg::*;

  light_t light_color;
  logic   hold;
  logic   clear_fault;
  logic   lamp_green;
  logic   lamp_yellow;
  logic   lamp_red;
  logic   fault;
  fault_t fault_code;

  modport master (
    output light_color, hold, clear_fault,
    input  lamp_green, lamp_yellow, lamp_red, fault, fault_code
  );

  modport slave (
    input  light_color, hold, clear_fault,
    output lamp_green, lamp_yellow, lamp_red, fault, fault_code
  );

endinterface

// File: rtl/left_signal_head_monitor_blinker.sv
// Blink phase generator for flashing lamps.
//   clk      system clock
//   reset    asynchronous, active-low
//   restart  restart at count 0 with phase ON at the next edge
//   phase    1 = lamp ON half, 0 = lamp OFF half; each half lasts BLINK_HALF cycles
module lamp_blinker #(
  parameter int unsigned BLINK_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase
);

  localparam int unsigned CntW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CntW'(BLINK_HALF - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/left_signal_head_monitor.sv
// Left-turn signal head monitor: registers the light code from the controller, decodes it to
// lamp enables and watches the code stream for illegal transitions, short yellow and stuck codes.
// Any fault is latched and forces flashing red until cleared while the controller shows RED.
//   clk    system clock
//   reset  asynchronous, active-low
//   bus    slave side of left_signal_head_monitor_if (code/hold/clear in, lamps/fault out)
module left_signal_head_monitor
  import left_signal_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 4,
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MAX_DWELL  = 64
) (
  input logic                        clk,
  input logic                        reset,
  left_signal_head_monitor_if.slave  bus
);

  localparam int unsigned DwellW = $clog2(MAX_DWELL + 2);

  light_t            code_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  mon_state_t        state_q, state_d;
  fault_t            fault_code_q, fault_code_d;
  fault_t            detect;
  logic              changed;
  logic              clear_ok;
  logic              enter_fault;
  logic              leave_fault;
  logic              blink_restart;
  logic              blink_phase;

  assign changed  = (bus.light_color != code_q);
  assign clear_ok = bus.clear_fault && (bus.light_color == L_RED);

  // Fault detection on the incoming sample; change and no-change cases are exclusive, so the
  // 01 > 10 > 11 priority reduces to illegal-before-short-yellow.
  always_comb begin
    detect = F_NONE;
    if (changed) begin
      if (!is_legal(code_q, bus.light_color)) begin
        detect = F_ILLEGAL;
      end else if (code_q == L_YELLOW && bus.light_color == L_RED &&
                   dwell_q < DwellW'(MIN_YELLOW)) begin
        detect = F_SHORT_YELLOW;
      end
    end else if (!bus.hold && dwell_q == DwellW'(MAX_DWELL)) begin
      detect = F_STUCK;
    end
  end

  // FSM next state; fault_code only changes on entry to / exit from FAULT.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    unique case (state_q)
      MON_MONITOR: begin
        if (detect != F_NONE) begin
          state_d      = MON_FAULT;
          fault_code_d = detect;
        end
      end
      MON_FAULT: begin
        if (clear_ok) begin
          state_d      = MON_MONITOR;
          fault_code_d = F_NONE;
        end
      end
      default: begin
        state_d      = MON_FAULT;
        fault_code_d = fault_code_q;
      end
    endcase
  end

  assign enter_fault = (state_q == MON_MONITOR) && (state_d == MON_FAULT);
  assign leave_fault = (state_q == MON_FAULT) && (state_d == MON_MONITOR);

  // Dwell counts consecutive samples of code_q; it keeps running in FAULT.
  always_comb begin
    dwell_d = dwell_q;
    if (changed || leave_fault) begin
      dwell_d = DwellW'(1);
    end else if (!bus.hold && dwell_q != DwellW'(MAX_DWELL + 1)) begin
      dwell_d = dwell_q + DwellW'(1);
    end
  end

  // Restart on FAULT entry (red blink) or on FY entry while the head is decoding normally.
  assign blink_restart = enter_fault ||
                         (state_d == MON_MONITOR && bus.light_color == L_FLASHING_YELLOW &&
                          code_q != L_FLASHING_YELLOW);

  lamp_blinker #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blinker (
    .clk     (clk),
    .reset   (reset),
    .restart (blink_restart),
    .phase   (blink_phase)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q       <= L_RED;
      dwell_q      <= DwellW'(1);
      state_q      <= MON_MONITOR;
      fault_code_q <= F_NONE;
    end else begin
      code_q       <= bus.light_color;
      dwell_q      <= dwell_d;
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Outputs decode only flops, so light_color reaches the lamps one cycle late with no
  // combinational input-to-output path.
  always_comb begin
    bus.lamp_green  = 1'b0;
    bus.lamp_yellow = 1'b0;
    bus.lamp_red    = 1'b0;
    bus.fault       = (state_q == MON_FAULT);
    bus.fault_code  = fault_code_q;
    if (state_q == MON_FAULT) begin
      bus.lamp_red = blink_phase;
    end else begin
      unique case (code_q)
        L_GREEN:           bus.lamp_green  = 1'b1;
        L_YELLOW:          bus.lamp_yellow = 1'b1;
        L_RED:             bus.lamp_red    = 1'b1;
        L_FLASHING_YELLOW: bus.lamp_yellow = blink_phase;
        default:           bus.lamp_red    = 1'b1;
      endcase
    end
  end

endmodule
